// File: rtl/cp0_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Package : cp0_defs
//  Coprocessor-0 register numbers, field positions, exception codes, vectors.
//  Revision: 1.0
// ============================================================================
package cp0_defs;

  localparam logic [4:0] c_REG_SR    = 5'd12;
  localparam logic [4:0] c_REG_CAUSE = 5'd13;
  localparam logic [4:0] c_REG_EPC   = 5'd14;
  localparam logic [4:0] c_REG_PRID  = 5'd15;

  localparam int c_SR_IE        = 0;
  localparam int c_SR_EXL       = 1;
  localparam int c_SR_IM_LO     = 10;
  localparam int c_SR_IM_HI     = 15;
  localparam int c_CAUSE_EXC_LO = 2;
  localparam int c_CAUSE_IP_LO  = 10;
  localparam int c_CAUSE_BD     = 31;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam logic [31:0] PRID    = 32'h2021_0707;
  localparam logic [31:0] HANDLER = 32'h0000_4180;

endpackage
`default_nettype wire

// File: rtl/cp0_unit.sv
`default_nettype none
// ============================================================================
//  Module  : cp0_unit
//  SR/Cause/EPC/PRId holder, interrupt/exception trap decision, mfc0/mtc0.
//  Revision: 1.0
// ============================================================================
module cp0_unit
  import cp0_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  a1,
  input  logic [4:0]  a2,
  input  logic [31:0] din,
  input  logic        we,
  input  logic [31:0] pc,
  input  logic        bd,
  input  logic [4:0]  exc_code,
  input  logic [5:0]  hwint,
  input  logic        exl_clr,
  output logic        irq,
  output logic [31:0] epc,
  output logic [31:0] dout
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc_code;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_wr_sr;
  logic        w_wr_epc;
  logic [31:0] w_trap_epc;

  assign w_int_req = (|(hwint & r_im)) & r_ie & ~r_exl;
  assign w_exc_req = (exc_code != EXC_INT) & ~r_exl;
  assign irq       = w_int_req | w_exc_req;

  assign w_wr_sr    = we & (a2 == c_REG_SR);
  assign w_wr_epc   = we & (a2 == c_REG_EPC);
  // Delay-slot trap restarts at the branch; subtraction wraps modulo 2^32.
  assign w_trap_epc = (bd ? (pc - 32'd4) : pc) & ~32'h3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_im       <= 6'd0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip       <= 6'd0;
      r_exc_code <= 5'd0;
      r_epc      <= 32'd0;
    end else begin
      r_ip <= hwint;
      if (irq) begin
        r_exl      <= 1'b1;
        r_exc_code <= w_int_req ? EXC_INT : exc_code;
        r_bd       <= bd;
        r_epc      <= w_trap_epc;
      end else begin
        if (w_wr_sr) begin
          r_im <= din[c_SR_IM_HI:c_SR_IM_LO];
          r_ie <= din[c_SR_IE];
        end
        if (exl_clr)
          r_exl <= 1'b0;
        else if (w_wr_sr)
          r_exl <= din[c_SR_EXL];
        if (w_wr_epc)
          r_epc <= din & ~32'h3;
      end
    end
  end

  assign epc = r_epc;

  always_comb begin
    dout = 32'd0;
    case (a1)
      c_REG_SR: begin
        dout[c_SR_IM_HI:c_SR_IM_LO] = r_im;
        dout[c_SR_EXL]              = r_exl;
        dout[c_SR_IE]               = r_ie;
      end
      c_REG_CAUSE: begin
        dout[c_CAUSE_BD]                          = r_bd;
        dout[c_CAUSE_IP_LO+5:c_CAUSE_IP_LO]       = r_ip;
        dout[c_CAUSE_EXC_LO+4:c_CAUSE_EXC_LO]     = r_exc_code;
      end
      c_REG_EPC:  dout = r_epc;
      c_REG_PRID: dout = PRID;
      default:    dout = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cp0_unit.sv
`default_nettype none
// ============================================================================
//  Module  : tb_cp0_unit
//  Directed self-checking bench for cp0_unit.
//  Revision: 1.0
// ============================================================================
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  a1 = 5'd0;
  logic [4:0]  a2 = 5'd0;
  logic [31:0] din = 32'd0;
  logic        we = 1'b0;
  logic [31:0] pc = 32'd0;
  logic        bd = 1'b0;
  logic [4:0]  exc_code = 5'd0;
  logic [5:0]  hwint = 6'd0;
  logic        exl_clr = 1'b0;
  logic        irq;
  logic [31:0] epc;
  logic [31:0] dout;

  int n_vec = 0;
  int n_bad = 0;

  cp0_unit u_dut (
    .clk      (clk),
    .reset    (reset),
    .a1       (a1),
    .a2       (a2),
    .din      (din),
    .we       (we),
    .pc       (pc),
    .bd       (bd),
    .exc_code (exc_code),
    .hwint    (hwint),
    .exl_clr  (exl_clr),
    .irq      (irq),
    .epc      (epc),
    .dout     (dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] r, input string tag, input logic [31:0] exp);
    a1 = r;
    #1;
    chk(tag, dout, exp);
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    we = 1'b1; a2 = r; din = d;
    tick();
    we = 1'b0; a2 = 5'd0; din = 32'd0;
  endtask

  initial begin
    // Mid-cycle asynchronous reset.
    #3 reset = 1'b1;
    #1;
    rd(5'd12, "rst_sr", 32'h0);
    rd(5'd13, "rst_cause", 32'h0);
    rd(5'd14, "rst_epc_rd", 32'h0);
    chk("rst_epc", epc, 32'h0);
    rd(5'd15, "prid", 32'h2021_0707);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // Enabled interrupt on line 0 traps.
    mtc0(5'd12, 32'h0000_0401);
    rd(5'd12, "sr_wr", 32'h0000_0401);
    hwint = 6'b000001; pc = 32'h3010;
    #1;
    chk("int_irq", {31'd0, irq}, 32'h1);
    tick();
    rd(5'd12, "int_sr_exl", 32'h0000_0403);
    rd(5'd13, "int_cause", 32'h0000_0400);
    chk("int_epc", epc, 32'h3010);
    chk("int_irq_exl", {31'd0, irq}, 32'h0);
    hwint = 6'b0;
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    rd(5'd12, "eret_sr", 32'h0000_0401);

    // Line 2 is not enabled by IM bit 10; IP still tracks it.
    hwint = 6'b000100;
    #1;
    chk("mask_im_irq", {31'd0, irq}, 32'h0);
    tick();
    rd(5'd13, "mask_im_ip", 32'h0000_1000);

    // IE only, no IM: pending line stays masked.
    mtc0(5'd12, 32'h0000_0001);
    hwint = 6'b000001;
    #1;
    chk("mask_irq", {31'd0, irq}, 32'h0);
    tick();
    rd(5'd13, "mask_cause", 32'h0000_0400);

    // Overflow in a delay slot.
    mtc0(5'd12, 32'h0);
    hwint = 6'b0; exc_code = 5'd12; bd = 1'b1; pc = 32'h3020;
    #1;
    chk("ov_irq", {31'd0, irq}, 32'h1);
    tick();
    exc_code = 5'd0; bd = 1'b0;
    rd(5'd13, "ov_cause", 32'h8000_0030);
    chk("ov_epc", epc, 32'h301C);

    // Nested exception while EXL=1 is ignored.
    exc_code = 5'd10;
    #1;
    chk("nest_irq", {31'd0, irq}, 32'h0);
    tick();
    rd(5'd13, "nest_cause", 32'h8000_0030);
    chk("nest_epc", epc, 32'h301C);

    // eret together with SR write setting EXL: eret wins, IM/IE still written.
    exc_code = 5'd0; hwint = 6'b000001;
    exl_clr = 1'b1; we = 1'b1; a2 = 5'd12; din = 32'h0000_0403;
    tick();
    exl_clr = 1'b0; we = 1'b0;
    rd(5'd12, "eret_wr_sr", 32'h0000_0401);

    // Pending interrupt + AdEL + EPC write in the same cycle.
    exc_code = 5'd4; pc = 32'h4000;
    we = 1'b1; a2 = 5'd14; din = 32'h0000_ABCD;
    #1;
    chk("simul_irq", {31'd0, irq}, 32'h1);
    tick();
    we = 1'b0; exc_code = 5'd0; hwint = 6'b0;
    rd(5'd13, "simul_cause", 32'h0000_0400);
    chk("simul_epc", epc, 32'h4000);

    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    rd(5'd12, "eret2_sr", 32'h0000_0401);

    // EPC write drops low bits.
    mtc0(5'd14, 32'h0000_1237);
    chk("epc_wr", epc, 32'h0000_1234);
    rd(5'd14, "epc_rd", 32'h0000_1234);

    // Delay-slot trap at pc=0 wraps.
    exc_code = 5'd5; pc = 32'h0; bd = 1'b1;
    tick();
    exc_code = 5'd0; bd = 1'b0;
    chk("wrap_epc", epc, 32'hFFFF_FFFC);
    rd(5'd13, "wrap_cause", 32'h8000_0014);

    // Cause is read-only; unused register numbers read zero.
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, "cause_ro", 32'h8000_0014);
    rd(5'd3, "unused_rd", 32'h0);

    // Reset mid-handler clears EXL at once; irq still follows exc_code.
    #2 reset = 1'b1;
    exc_code = 5'd4;
    #1;
    rd(5'd12, "rst_mid_sr", 32'h0);
    chk("rst_mid_epc", epc, 32'h0);
    chk("rst_mid_irq", {31'd0, irq}, 32'h1);
    tick();
    rd(5'd13, "rst_hold_cause", 32'h0);
    exc_code = 5'd0;
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
